// File: rtl/ochiba_eth_tx_serializer_if.sv
// Datapath word-write port and MAC byte stream of the Ethernet transmit serializer.
interface ochiba_eth_tx_serializer_if #(parameter int WIDTH = 1048);
    logic [WIDTH-1:0] ethernet_tx;
    logic             ethernet_tx_we;
    logic             txfifofull;
    logic             txfifoemp;
    logic             tx_overflow;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx_sof;
    logic             tx_eof;
    logic             tx_busy;

    modport master (
        output ethernet_tx, ethernet_tx_we, tx_ready,
        input  txfifofull, txfifoemp, tx_overflow, tx_data, tx_valid, tx_sof, tx_eof, tx_busy
    );
    modport slave (
        input  ethernet_tx, ethernet_tx_we, tx_ready,
        output txfifofull, txfifoemp, tx_overflow, tx_data, tx_valid, tx_sof, tx_eof, tx_busy
    );
endinterface

// File: rtl/ochiba_eth_tx_serializer.sv
// Buffers wide datapath words in a small FIFO and streams each one MSB byte first to the MAC.
module ochiba_eth_tx_serializer #(
    parameter int WIDTH = 1048,
    parameter int DEPTH = 2
) (
    input logic                       clk,
    input logic                       reset,
    ochiba_eth_tx_serializer_if.slave bus
);
    localparam int NBYTES = WIDTH / 8;
    localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int BW     = $clog2(NBYTES);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] sh_q;
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic [BW-1:0]    bcnt_q;
    logic             ovf_q;
    logic             wr_ok, pop, load, shift;
    logic             have_word, last_byte;

    // The serializer only sees the registered count, so a fresh write waits one cycle.
    assign have_word = (count_q != '0);
    assign last_byte = (bcnt_q == BW'(NBYTES - 1));
    assign wr_ok     = bus.ethernet_tx_we && (count_q != CW'(DEPTH));

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: if (have_word) begin
                pop     = 1'b1;
                load    = 1'b1;
                state_d = SEND;
            end
            SEND: if (bus.tx_ready) begin
                if (!last_byte) begin
                    shift = 1'b1;
                end else if (have_word) begin
                    pop  = 1'b1;
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr_q] <= bus.ethernet_tx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            bcnt_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wr_ok) wptr_q <= wptr_q + PW'(1);
            if (pop)   rptr_q <= rptr_q + PW'(1);
            case ({wr_ok, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            // A full buffer drops the write even if a pop frees a slot on the same edge.
            if (bus.ethernet_tx_we && !wr_ok) ovf_q <= 1'b1;
            if (load) begin
                sh_q   <= mem[rptr_q];
                bcnt_q <= '0;
            end else if (shift) begin
                sh_q   <= sh_q << 8;
                bcnt_q <= bcnt_q + BW'(1);
            end
        end
    end

    assign bus.tx_valid    = (state_q == SEND);
    assign bus.tx_busy     = (state_q == SEND);
    assign bus.tx_data     = bus.tx_valid ? sh_q[WIDTH-1 -: 8] : 8'h00;
    assign bus.tx_sof      = bus.tx_valid && (bcnt_q == '0);
    assign bus.tx_eof      = bus.tx_valid && last_byte;
    assign bus.txfifofull  = (count_q == CW'(DEPTH));
    assign bus.txfifoemp   = !have_word;
    assign bus.tx_overflow = ovf_q;
endmodule
